// File: rtl/dm_pkg.sv
// ----------------------------------------------------------------------------
// dm_pkg
// Shared types and helpers for the MIPS data memory (data_mem_pipe).
//   dm_op_e      : request op codes (loads 000-100, stores 101-111)
//   dm_cause_e   : response cause codes
//   dm_state_e   : controller states (clear-after-reset, normal operation)
//   is_store     : op is SB/SH/SW
//   is_misaligned: op/address-low-bits combination violates natural alignment
//   byte_parity  : even-parity bit per byte of a 32-bit word
// ----------------------------------------------------------------------------
package dm_pkg;

    typedef enum logic [2:0] {
        OP_LB  = 3'b000,
        OP_LBU = 3'b001,
        OP_LH  = 3'b010,
        OP_LHU = 3'b011,
        OP_LW  = 3'b100,
        OP_SB  = 3'b101,
        OP_SH  = 3'b110,
        OP_SW  = 3'b111
    } dm_op_e;

    typedef enum logic [1:0] {
        CAUSE_OK       = 2'b00,
        CAUSE_MISALIGN = 2'b01,
        CAUSE_PARITY   = 2'b10
    } dm_cause_e;

    typedef enum logic {
        ST_INIT = 1'b0,
        ST_RUN  = 1'b1
    } dm_state_e;

    function automatic logic is_store(input logic [2:0] op);
        logic res;
        case (dm_op_e'(op))
            OP_SB, OP_SH, OP_SW: res = 1'b1;
            default:             res = 1'b0;
        endcase
        return res;
    endfunction

    function automatic logic is_misaligned(input logic [2:0] op, input logic [1:0] addr_lo);
        logic res;
        case (dm_op_e'(op))
            OP_LH, OP_LHU, OP_SH: res = addr_lo[0];
            OP_LW, OP_SW:         res = (addr_lo != 2'b00);
            default:              res = 1'b0;
        endcase
        return res;
    endfunction

    // Even parity: the stored bit makes the count of ones in byte+bit even.
    function automatic logic [3:0] byte_parity(input logic [31:0] word);
        logic [3:0] res;
        for (int i = 0; i < 4; i++) begin
            res[i] = ^word[8*i +: 8];
        end
        return res;
    endfunction

endpackage

// File: rtl/data_mem_lane.sv
// ----------------------------------------------------------------------------
// data_mem_lane
// Combinational byte-lane steering for the data memory.
//   op        in  3   request op code (dm_op_e)
//   addr_lo   in  2   byte address bits [1:0]
//   rd_word   in  32  word currently stored at the addressed index
//   wdata     in  32  store data (low byte/half/word used)
//   load_data out 32  selected lane, sign/zero extended per op
//   lane_en   out 4   byte lanes touched by the access (loads and stores)
//   wr_word   out 32  store data replicated onto every lane; lane_en picks
// ----------------------------------------------------------------------------
module data_mem_lane
    import dm_pkg::*;
(
    input  logic [2:0]  op,
    input  logic [1:0]  addr_lo,
    input  logic [31:0] rd_word,
    input  logic [31:0] wdata,
    output logic [31:0] load_data,
    output logic [3:0]  lane_en,
    output logic [31:0] wr_word
);

    logic [7:0]  byte_s;
    logic [15:0] half_s;

    // Lane extraction used by the byte and half load paths.
    always_comb begin
        byte_s = rd_word[{addr_lo, 3'b000} +: 8];
        half_s = rd_word[{addr_lo[1], 4'b0000} +: 16];
    end

    // Access width decode: lane enables, load extension, store replication.
    always_comb begin
        load_data = 32'h0000_0000;
        lane_en   = 4'b0000;
        wr_word   = 32'h0000_0000;
        case (dm_op_e'(op))
            OP_LB, OP_LBU, OP_SB: begin
                lane_en   = 4'b0001 << addr_lo;
                wr_word   = {4{wdata[7:0]}};
                if (dm_op_e'(op) == OP_LB) begin
                    load_data = {{24{byte_s[7]}}, byte_s};
                end else begin
                    load_data = {24'h00_0000, byte_s};
                end
            end
            OP_LH, OP_LHU, OP_SH: begin
                lane_en   = addr_lo[1] ? 4'b1100 : 4'b0011;
                wr_word   = {2{wdata[15:0]}};
                if (dm_op_e'(op) == OP_LH) begin
                    load_data = {{16{half_s[15]}}, half_s};
                end else begin
                    load_data = {16'h0000, half_s};
                end
            end
            OP_LW, OP_SW: begin
                lane_en   = 4'b1111;
                wr_word   = wdata;
                load_data = rd_word;
            end
            default: begin
                lane_en   = 4'b0000;
                wr_word   = 32'h0000_0000;
                load_data = 32'h0000_0000;
            end
        endcase
    end

endmodule

// File: rtl/data_mem_pipe.sv
// ----------------------------------------------------------------------------
// data_mem_pipe
// Clocked little-endian data memory for the MIPS MEM stage with valid/ready
// request and response handshakes and a one-cycle registered response.
// After reset the array is cleared one word per cycle (DEPTH_WORDS cycles)
// before requests are accepted.
//
// Optional build macro DM_PARITY_EN: keeps one even-parity bit per byte,
// checks accessed lanes on loads (cause 10) and adds the parity_flip test
// hook that corrupts the parity written by the next store.
//
// Ports:
//   clk, rst_n             clock, asynchronous active-low reset
//   parity_flip[3:0]       (DM_PARITY_EN only) XOR mask on stored parity
//   req_valid/req_ready    request handshake
//   req_op, req_addr, req_wdata   op code, byte address, store data
//   rsp_valid/rsp_ready    response handshake
//   rsp_rdata, rsp_cause   load result / cause (00 ok, 01 misalign, 10 parity)
//   init_done              post-reset clear finished
// ----------------------------------------------------------------------------
module data_mem_pipe
    import dm_pkg::*;
#(
    parameter int DEPTH_WORDS = 2048,
    parameter int ADDR_W      = 32
) (
    input  logic              clk,
    input  logic              rst_n,
`ifdef DM_PARITY_EN
    input  logic [3:0]        parity_flip,
`endif
    input  logic              req_valid,
    output logic              req_ready,
    input  logic [2:0]        req_op,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [31:0]       req_wdata,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [31:0]       rsp_rdata,
    output logic [1:0]        rsp_cause,
    output logic              init_done
);

    localparam int IDX_W = $clog2(DEPTH_WORDS);

    dm_state_e          state_r, state_s;
    logic [IDX_W-1:0]   cnt_r, cnt_s;
    logic [31:0]        mem_r [DEPTH_WORDS];

    logic               rsp_valid_r;
    logic [31:0]        rsp_rdata_r;
    logic [1:0]         rsp_cause_r;

    logic               req_ready_s;
    logic               accept_s;
    logic [IDX_W-1:0]   idx_s;
    logic [31:0]        rd_word_s;
    logic               store_s;
    logic               mis_s;
    logic               wr_en_s;
    logic [31:0]        load_data_s;
    logic [3:0]         lane_en_s;
    logic [31:0]        wr_word_s;
    logic [31:0]        rsp_rdata_s;
    logic [1:0]         rsp_cause_s;

    // Address bits above the array size are deliberately ignored (wrap).
    logic               unused_addr_s;
    assign unused_addr_s = ^req_addr[ADDR_W-1:IDX_W+2];

    // Request decode and handshake.
    always_comb begin
        req_ready_s = (state_r == ST_RUN) && (!rsp_valid_r || rsp_ready);
        accept_s    = req_valid && req_ready_s;
        idx_s       = req_addr[IDX_W+1:2];
        rd_word_s   = mem_r[idx_s];
        store_s     = is_store(req_op);
        mis_s       = is_misaligned(req_op, req_addr[1:0]);
        wr_en_s     = accept_s && store_s && !mis_s;
    end

    data_mem_lane u_lane (
        .op        (req_op),
        .addr_lo   (req_addr[1:0]),
        .rd_word   (rd_word_s),
        .wdata     (req_wdata),
        .load_data (load_data_s),
        .lane_en   (lane_en_s),
        .wr_word   (wr_word_s)
    );

`ifdef DM_PARITY_EN
    logic [3:0] par_mem_r [DEPTH_WORDS];
    logic [3:0] wr_par_s;
    logic       par_err_s;

    // Parity to store and parity check on the lanes the load touches.
    always_comb begin
        wr_par_s  = byte_parity(wr_word_s) ^ parity_flip;
        par_err_s = |(lane_en_s & (byte_parity(rd_word_s) ^ par_mem_r[idx_s]));
    end

    // Parity array: cleared with the data during INIT, per-lane on stores.
    always_ff @(posedge clk) begin
        if (state_r == ST_INIT) begin
            par_mem_r[cnt_r] <= 4'b0000;
        end else if (wr_en_s) begin
            for (int i = 0; i < 4; i++) begin
                if (lane_en_s[i]) begin
                    par_mem_r[idx_s][i] <= wr_par_s[i];
                end
            end
        end
    end
`endif

    // Controller next state: sweep every word during INIT, then run.
    always_comb begin
        state_s = state_r;
        cnt_s   = cnt_r;
        case (state_r)
            ST_INIT: begin
                cnt_s = cnt_r + IDX_W'(1);
                if (cnt_r == IDX_W'(DEPTH_WORDS - 1)) begin
                    state_s = ST_RUN;
                end else begin
                    state_s = ST_INIT;
                end
            end
            ST_RUN: begin
                state_s = ST_RUN;
                cnt_s   = cnt_r;
            end
            default: begin
                state_s = ST_INIT;
                cnt_s   = {IDX_W{1'b0}};
            end
        endcase
    end

    // Controller state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= ST_INIT;
            cnt_r   <= {IDX_W{1'b0}};
        end else begin
            state_r <= state_s;
            cnt_r   <= cnt_s;
        end
    end

    // Data array: zero fill during INIT, byte-lane writes on accepted stores.
    always_ff @(posedge clk) begin
        if (state_r == ST_INIT) begin
            mem_r[cnt_r] <= 32'h0000_0000;
        end else if (wr_en_s) begin
            for (int i = 0; i < 4; i++) begin
                if (lane_en_s[i]) begin
                    mem_r[idx_s][8*i +: 8] <= wr_word_s[8*i +: 8];
                end
            end
        end
    end

    // Response payload; misalignment outranks a parity error.
    always_comb begin
        rsp_rdata_s = 32'h0000_0000;
        rsp_cause_s = CAUSE_OK;
        if (mis_s) begin
            rsp_rdata_s = 32'h0000_0000;
            rsp_cause_s = CAUSE_MISALIGN;
        end else if (store_s) begin
            rsp_rdata_s = 32'h0000_0000;
            rsp_cause_s = CAUSE_OK;
`ifdef DM_PARITY_EN
        end else if (par_err_s) begin
            rsp_rdata_s = 32'h0000_0000;
            rsp_cause_s = CAUSE_PARITY;
`endif
        end else begin
            rsp_rdata_s = load_data_s;
            rsp_cause_s = CAUSE_OK;
        end
    end

    // Response register: reload on accept, drain on handshake, else hold.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rsp_valid_r <= 1'b0;
            rsp_rdata_r <= 32'h0000_0000;
            rsp_cause_r <= 2'b00;
        end else if (accept_s) begin
            rsp_valid_r <= 1'b1;
            rsp_rdata_r <= rsp_rdata_s;
            rsp_cause_r <= rsp_cause_s;
        end else if (rsp_ready) begin
            rsp_valid_r <= 1'b0;
            rsp_rdata_r <= rsp_rdata_r;
            rsp_cause_r <= rsp_cause_r;
        end else begin
            rsp_valid_r <= rsp_valid_r;
            rsp_rdata_r <= rsp_rdata_r;
            rsp_cause_r <= rsp_cause_r;
        end
    end

    assign req_ready = req_ready_s;
    assign rsp_valid = rsp_valid_r;
    assign rsp_rdata = rsp_rdata_r;
    assign rsp_cause = rsp_cause_r;
    assign init_done = (state_r == ST_RUN);

endmodule

// File: tb/tb_data_mem_pipe.sv
// ----------------------------------------------------------------------------
// tb_data_mem_pipe
// Self-checking bench for data_mem_pipe: directed vector table, multi-cycle
// backpressure and reset sequences, and random traffic scored against a
// byte-level reference memory. Honours DM_PARITY_EN when defined.
// ----------------------------------------------------------------------------
module tb_data_mem_pipe;

    localparam int DEPTH = 2048;
    localparam logic [2:0] LB = 3'b000, LBU = 3'b001, LH = 3'b010, LHU = 3'b011,
                           LW = 3'b100, SB = 3'b101, SH = 3'b110, SW = 3'b111;

    logic        clk;
    logic        rst_n;
    logic [3:0]  parity_flip;
    logic        req_valid;
    logic        req_ready;
    logic [2:0]  req_op;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [31:0] rsp_rdata;
    logic [1:0]  rsp_cause;
    logic        init_done;

    data_mem_pipe #(.DEPTH_WORDS(DEPTH), .ADDR_W(32)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
`ifdef DM_PARITY_EN
        .parity_flip(parity_flip),
`endif
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_op    (req_op),
        .req_addr  (req_addr),
        .req_wdata (req_wdata),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_rdata (rsp_rdata),
        .rsp_cause (rsp_cause),
        .init_done (init_done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    // Reference memory: plain words plus a per-byte "parity corrupted" flag.
    logic [31:0] mem_m [DEPTH];
    logic [3:0]  bad_m [DEPTH];
    typedef struct { logic [31:0] rdata; logic [1:0] cause; } exp_t;
    exp_t exp_q[$];

    int          n_rsp = 0;
    logic [31:0] last_rdata;
    logic [1:0]  last_cause;
    logic        stall_prev = 1'b0;
    logic [31:0] prev_rdata;
    logic [1:0]  prev_cause;

    typedef struct {
        logic [2:0]  op;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] exp_rdata;
        logic [1:0]  exp_cause;
    } vec_t;
    vec_t vecs[17];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, req);
        end
    endtask

    function automatic void model_clear();
        for (int i = 0; i < DEPTH; i++) begin
            mem_m[i] = 32'h0;
            bad_m[i] = 4'h0;
        end
        exp_q.delete();
    endfunction

    // Reference behaviour of one accepted request.
    function automatic void model_req(input logic [2:0] op, input logic [31:0] addr,
                                      input logic [31:0] wdata, input logic [3:0] flip);
        int idx  = int'((addr >> 2) % DEPTH);
        int lane = int'(addr[1:0]);
        int size = (op == LB || op == LBU || op == SB) ? 1 :
                   (op == LH || op == LHU || op == SH) ? 2 : 4;
        bit store = (op == SB || op == SH || op == SW);
        logic [31:0] val = 32'h0;
        bit bad = 1'b0;
        exp_t e;
        if ((lane % size) != 0) begin
            e.rdata = 32'h0; e.cause = 2'b01;
        end else if (store) begin
            for (int b = 0; b < size; b++) begin
                mem_m[idx][8*(lane+b) +: 8] = wdata[8*b +: 8];
                bad_m[idx][lane+b] = flip[lane+b];
            end
            e.rdata = 32'h0; e.cause = 2'b00;
        end else begin
            for (int b = 0; b < size; b++) begin
                val[8*b +: 8] = mem_m[idx][8*(lane+b) +: 8];
                if (bad_m[idx][lane+b]) bad = 1'b1;
            end
            if ((op == LB || op == LH) && val[8*size-1]) val = val | (32'hFFFF_FFFF << (8*size));
            if (bad) begin
                e.rdata = 32'h0; e.cause = 2'b10;
            end else begin
                e.rdata = val; e.cause = 2'b00;
            end
        end
        exp_q.push_back(e);
    endfunction

    logic [3:0] pflip = 4'h0;

    // One clock cycle: drive at negedge, then score response and request.
    task automatic step(input logic v, input logic [2:0] op, input logic [31:0] addr,
                        input logic [31:0] wdata, input logic rr, output logic acc);
        exp_t e;
        @(negedge clk);
        req_valid = v; req_op = op; req_addr = addr; req_wdata = wdata;
        rsp_ready = rr; parity_flip = pflip;
        #1;
        if (stall_prev) begin
            check("hold_valid", {31'h0, rsp_valid}, 32'h1);
            check("hold_rdata", rsp_rdata, prev_rdata);
            check("hold_cause", {30'h0, rsp_cause}, {30'h0, prev_cause});
        end
        if (rsp_valid && !rsp_ready) check("stall_req_ready", {31'h0, req_ready}, 32'h0);
        if (rsp_valid && rsp_ready) begin
            if (exp_q.size() == 0) begin
                checks++; errors++;
                $display("FAIL spurious_rsp: got rdata %h with no request outstanding", rsp_rdata);
            end else begin
                e = exp_q.pop_front();
                check("rsp_rdata", rsp_rdata, e.rdata);
                check("rsp_cause", {30'h0, rsp_cause}, {30'h0, e.cause});
            end
            n_rsp++;
            last_rdata = rsp_rdata;
            last_cause = rsp_cause;
        end
        acc = req_valid && req_ready;
        if (acc) model_req(op, addr, wdata, pflip);
        stall_prev = rsp_valid && !rsp_ready;
        prev_rdata = rsp_rdata;
        prev_cause = rsp_cause;
    endtask

    // Issue one request with rsp_ready high and return its response.
    task automatic send_wait(input logic [2:0] op, input logic [31:0] addr, input logic [31:0] wdata,
                             output logic [31:0] rdata, output logic [1:0] cause);
        logic acc = 1'b0;
        int n = 0;
        int base;
        while (!acc && n < 50) begin
            step(1'b1, op, addr, wdata, 1'b1, acc);
            n++;
        end
        if (!acc) begin
            checks++; errors++;
            $display("FAIL accept_timeout: got no accept expected accept within 50 cycles");
        end
        base = n_rsp;
        n = 0;
        while (n_rsp == base && n < 10) begin
            step(1'b0, LW, 32'h0, 32'h0, 1'b1, acc);
            n++;
        end
        if (n_rsp == base) begin
            checks++; errors++;
            $display("FAIL rsp_timeout: got no response expected one within 10 cycles");
        end
        rdata = last_rdata;
        cause = last_cause;
    endtask

    // Drain outstanding responses with rsp_ready high.
    task automatic drain();
        logic acc;
        int n = 0;
        while ((exp_q.size() != 0 || rsp_valid) && n < 30) begin
            step(1'b0, LW, 32'h0, 32'h0, 1'b1, acc);
            n++;
        end
        check("drain_empty", exp_q.size(), 32'd0);
    endtask

    task automatic wait_init(input string name);
        int n = 0;
        int early = 0;
        while (!init_done && n < 3000) begin
            @(posedge clk); #1;
            n++;
            if (!init_done && req_ready) early++;
        end
        check({name, "_cycles"}, n, DEPTH);
        check({name, "_ready_low"}, early, 32'd0);
    endtask

    initial begin
        logic [31:0] rd;
        logic [1:0]  cs;
        logic        acc;
        int          idx, cyc, base;
        logic [2:0]  t5_op [12];
        logic [31:0] t5_addr [12];
        logic [31:0] t5_data [12];
        logic        cur_v;
        logic [2:0]  cur_op;
        logic [31:0] cur_addr, cur_data;

        vecs[0]  = '{SW,  32'h0000_0100, 32'h8899_AABB, 32'h0000_0000, 2'b00};
        vecs[1]  = '{LB,  32'h0000_0101, 32'h0,         32'hFFFF_FFAA, 2'b00};
        vecs[2]  = '{LBU, 32'h0000_0103, 32'h0,         32'h0000_0088, 2'b00};
        vecs[3]  = '{LH,  32'h0000_0102, 32'h0,         32'hFFFF_8899, 2'b00};
        vecs[4]  = '{LHU, 32'h0000_0100, 32'h0,         32'h0000_AABB, 2'b00};
        vecs[5]  = '{SW,  32'h0000_0104, 32'hFFFF_FFFF, 32'h0000_0000, 2'b00};
        vecs[6]  = '{SB,  32'h0000_0104, 32'h0000_0055, 32'h0000_0000, 2'b00};
        vecs[7]  = '{SH,  32'h0000_0106, 32'h0000_1234, 32'h0000_0000, 2'b00};
        vecs[8]  = '{LW,  32'h0000_0104, 32'h0,         32'h1234_FF55, 2'b00};
        vecs[9]  = '{LW,  32'h0000_0102, 32'h0,         32'h0000_0000, 2'b01};
        vecs[10] = '{SH,  32'h0000_0101, 32'h0000_DEAD, 32'h0000_0000, 2'b01};
        vecs[11] = '{LW,  32'h0000_0100, 32'h0,         32'h8899_AABB, 2'b00};
        vecs[12] = '{LW,  32'h0000_2100, 32'h0,         32'h8899_AABB, 2'b00};
        vecs[13] = '{LW,  32'hFFFF_E104, 32'h0,         32'h1234_FF55, 2'b00};
        vecs[14] = '{LBU, 32'h0000_0107, 32'h0,         32'h0000_0012, 2'b00};
        vecs[15] = '{LB,  32'h0000_0105, 32'h0,         32'hFFFF_FFFF, 2'b00};
        vecs[16] = '{LHU, 32'h0000_0103, 32'h0,         32'h0000_0000, 2'b01};

        model_clear();
        rst_n = 1'b0; req_valid = 1'b1; req_op = LW; req_addr = 32'h0; req_wdata = 32'h0;
        rsp_ready = 1'b1; parity_flip = 4'h0;
        #12;
        check("rst_req_ready", {31'h0, req_ready}, 32'h0);
        check("rst_rsp_valid", {31'h0, rsp_valid}, 32'h0);
        check("rst_rsp_rdata", rsp_rdata, 32'h0);
        check("rst_rsp_cause", {30'h0, rsp_cause}, 32'h0);
        check("rst_init_done", {31'h0, init_done}, 32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        wait_init("init");
        check("init_done", {31'h0, init_done}, 32'h1);
        send_wait(LW, 32'h0, 32'h0, rd, cs);
        check("lw0_after_init", rd, 32'h0);

        // Directed vectors.
        for (int i = 0; i < 17; i++) begin
            send_wait(vecs[i].op, vecs[i].addr, vecs[i].wdata, rd, cs);
            check($sformatf("vec%0d_rdata", i), rd, vecs[i].exp_rdata);
            check($sformatf("vec%0d_cause", i), {30'h0, cs}, {30'h0, vecs[i].exp_cause});
        end

        // Back-to-back stores/loads with a 3-cycle response stall.
        for (int k = 0; k < 6; k++) begin
            t5_op[2*k] = SW;   t5_addr[2*k] = 32'h180 + 32'(4*k); t5_data[2*k] = $urandom;
            t5_op[2*k+1] = LW; t5_addr[2*k+1] = 32'h180 + 32'(4*k); t5_data[2*k+1] = 32'h0;
        end
        base = n_rsp; idx = 0; cyc = 0;
        while (idx < 12 && cyc < 200) begin
            step(1'b1, t5_op[idx], t5_addr[idx], t5_data[idx], !(cyc >= 3 && cyc < 6), acc);
            if (acc) idx++;
            cyc++;
        end
        check("b2b_cycles", cyc, 32'd15);
        drain();
        check("b2b_rsp_count", n_rsp - base, 32'd12);

`ifdef DM_PARITY_EN
        pflip = 4'b0001;
        send_wait(SW, 32'h200, 32'hA5A5_A5A5, rd, cs);
        pflip = 4'b0000;
        send_wait(LBU, 32'h201, 32'h0, rd, cs);
        check("par_ok_rdata", rd, 32'h0000_00A5);
        check("par_ok_cause", {30'h0, cs}, 32'h0);
        send_wait(LBU, 32'h200, 32'h0, rd, cs);
        check("par_err_rdata", rd, 32'h0);
        check("par_err_cause", {30'h0, cs}, 32'h2);
        send_wait(LH, 32'h201, 32'h0, rd, cs);
        check("par_misalign_first", {30'h0, cs}, 32'h1);
        send_wait(SB, 32'h200, 32'h0000_003C, rd, cs);
        send_wait(LW, 32'h200, 32'h0, rd, cs);
        check("par_fixed_rdata", rd, 32'hA5A5_A53C);
`endif

        // Random traffic against the reference model.
        cur_v = 1'b0; cur_op = LW; cur_addr = 32'h0; cur_data = 32'h0;
        for (int c = 0; c < 400; c++) begin
            if (!cur_v) begin
                cur_v    = ($urandom_range(0, 4) != 0);
                cur_op   = 3'($urandom_range(0, 7));
                cur_addr = ($urandom & 32'hFFFF_E000) | (32'h300 + 32'($urandom_range(0, 63)));
                cur_data = $urandom;
            end
            step(cur_v, cur_op, cur_addr, cur_data, ($urandom_range(0, 3) != 0), acc);
            if (acc) cur_v = 1'b0;
        end
        drain();

        // Reset in the middle of traffic with a stalled response.
        step(1'b1, SW, 32'h100, 32'h1111_2222, 1'b0, acc);
        step(1'b1, LW, 32'h100, 32'h0, 1'b0, acc);
        #2;
        rst_n = 1'b0;
        #1;
        check("midrst_rsp_valid", {31'h0, rsp_valid}, 32'h0);
        check("midrst_init_done", {31'h0, init_done}, 32'h0);
        model_clear();
        stall_prev = 1'b0;
        req_valid = 1'b0;
        rsp_ready = 1'b1;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        wait_init("reinit");
        send_wait(LW, 32'h100, 32'h0, rd, cs);
        check("reinit_cleared", rd, 32'h0);
        send_wait(LW, 32'h104, 32'h0, rd, cs);
        check("reinit_cleared2", rd, 32'h0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
